// File: rtl/alarm_sensor_frontend.sv
// Conditions smoke/rain levels and door/motion contacts into a registered 3-bit alarm vector; fire/rain assert after PERSIST samples, burglar after motion or entry delay.
// No backpressure: every input is sampled on every clk edge and all outputs are registers.
module alarm_sensor_frontend #(
   parameter logic [7:0]  SMOKE_ON    = 8'd150,
   parameter logic [7:0]  SMOKE_OFF   = 8'd100,
   parameter logic [7:0]  RAIN_ON     = 8'd80,
   parameter logic [7:0]  RAIN_OFF    = 8'd40,
   parameter int unsigned PERSIST     = 4,
   parameter int unsigned ENTRY_DELAY = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] smoke_level,
   input  logic [7:0] rain_level,
   input  logic       door_open,
   input  logic       motion,
   input  logic       arm,
   input  logic       disarm,
   input  logic       fire_ack,
   output logic [2:0] state,
   output logic       armed,
   output logic       entry_pending,
   output logic       changed
);

   localparam logic [3:0] PERSIST_C  = PERSIST[3:0];
   localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DELAY - 1);

   typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_ENTRY, S_ALARM} fsm_t;

   fsm_t       fsm;
   logic [7:0] entry_cnt;
   logic [3:0] fire_cnt, fire_cnt_nxt;
   logic [3:0] rain_cnt, rain_cnt_nxt;
   logic       fire_q, rain_q, burg_q;
   logic       fire_nxt, rain_nxt, burg_nxt;
   logic [2:0] state_nxt;

   assign state = {rain_q, burg_q, fire_q};

   // Fire: persistence counter saturates; the latch only releases on ack once smoke has cleared.
   always_comb begin
      fire_cnt_nxt = 4'd0;
      if (smoke_level >= SMOKE_ON)
         fire_cnt_nxt = (fire_cnt == PERSIST_C) ? PERSIST_C : fire_cnt + 4'd1;
      fire_nxt = fire_q;
      if (smoke_level >= SMOKE_ON && fire_cnt_nxt == PERSIST_C)
         fire_nxt = 1'b1;
      else if (fire_ack && smoke_level < SMOKE_OFF)
         fire_nxt = 1'b0;
   end

   // Rain: one counter serves both directions since only one run is tracked at a time.
   always_comb begin
      rain_cnt_nxt = 4'd0;
      rain_nxt     = rain_q;
      if (!rain_q && rain_level >= RAIN_ON) begin
         if (rain_cnt + 4'd1 == PERSIST_C) rain_nxt = 1'b1;
         else                              rain_cnt_nxt = rain_cnt + 4'd1;
      end else if (rain_q && rain_level < RAIN_OFF) begin
         if (rain_cnt + 4'd1 == PERSIST_C) rain_nxt = 1'b0;
         else                              rain_cnt_nxt = rain_cnt + 4'd1;
      end
   end

   always_comb begin
      burg_nxt = 1'b0;
      case (fsm)
         S_ARMED:  burg_nxt = !disarm && motion;
         S_ENTRY:  burg_nxt = !disarm && (entry_cnt == 8'd0);
         S_ALARM:  burg_nxt = !disarm;
         default:  burg_nxt = 1'b0;
      endcase
   end

   assign state_nxt = {rain_nxt, burg_nxt, fire_nxt};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fire_cnt <= 4'd0;
         rain_cnt <= 4'd0;
         fire_q   <= 1'b0;
         rain_q   <= 1'b0;
         changed  <= 1'b0;
      end else begin
         fire_cnt <= fire_cnt_nxt;
         rain_cnt <= rain_cnt_nxt;
         fire_q   <= fire_nxt;
         rain_q   <= rain_nxt;
         changed  <= (state_nxt != state);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm           <= S_DISARMED;
         entry_cnt     <= 8'd0;
         burg_q        <= 1'b0;
         armed         <= 1'b0;
         entry_pending <= 1'b0;
      end else begin
         burg_q <= burg_nxt;
         case (fsm)
            S_DISARMED: begin
               if (arm && !disarm) begin
                  fsm   <= S_ARMED;
                  armed <= 1'b1;
               end
            end
            S_ARMED: begin
               if (disarm) begin
                  fsm   <= S_DISARMED;
                  armed <= 1'b0;
               end else if (motion) begin
                  fsm <= S_ALARM;
               end else if (door_open) begin
                  fsm           <= S_ENTRY;
                  entry_cnt     <= ENTRY_LOAD;
                  entry_pending <= 1'b1;
               end
            end
            S_ENTRY: begin
               if (disarm) begin
                  fsm           <= S_DISARMED;
                  armed         <= 1'b0;
                  entry_pending <= 1'b0;
               end else if (entry_cnt == 8'd0) begin
                  fsm           <= S_ALARM;
                  entry_pending <= 1'b0;
               end else begin
                  entry_cnt <= entry_cnt - 8'd1;
               end
            end
            default: begin
               if (disarm) begin
                  fsm   <= S_DISARMED;
                  armed <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_sensor_frontend.sv
// Bench for alarm_sensor_frontend: directed walk through the feature list, then randomized stimulus
// compared every cycle against a sample-history / event-time reference model.
module tb_alarm_sensor_frontend;

   localparam logic [7:0] SMOKE_ON = 8'd150, SMOKE_OFF = 8'd100;
   localparam logic [7:0] RAIN_ON = 8'd80, RAIN_OFF = 8'd40;
   localparam int P = 4, ENTRY_DELAY = 16;
   localparam int M_DIS = 0, M_ARMED = 1, M_ENTRY = 2, M_ALARM = 3;

   logic       clk, reset;
   logic [7:0] smoke_level, rain_level;
   logic       door_open, motion, arm, disarm, fire_ack;
   logic [2:0] state;
   logic       armed, entry_pending, changed;

   int n_checks = 0, n_fail = 0;

   logic [7:0] smoke_h[$], rain_h[$];
   bit         m_fire, m_rain;
   int         m_mode, edge_cnt, entry_edge;
   logic [2:0] exp_state, prev_state;
   logic       exp_changed;

   alarm_sensor_frontend dut (
      .clk(clk), .reset(reset), .smoke_level(smoke_level), .rain_level(rain_level),
      .door_open(door_open), .motion(motion), .arm(arm), .disarm(disarm), .fire_ack(fire_ack),
      .state(state), .armed(armed), .entry_pending(entry_pending), .changed(changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      smoke_h.delete();
      rain_h.delete();
      m_fire = 0; m_rain = 0; m_mode = M_DIS;
      prev_state = 3'b000; exp_state = 3'b000; exp_changed = 1'b0;
   endtask

   // Fire/rain decided from the last P samples; the burglar path from elapsed edges since entry.
   task automatic model_step();
      bit smoke_all_hi, rain_all_hi, rain_all_lo;
      edge_cnt++;
      smoke_h.push_back(smoke_level);
      rain_h.push_back(rain_level);
      if (smoke_h.size() > P) void'(smoke_h.pop_front());
      if (rain_h.size() > P) void'(rain_h.pop_front());
      smoke_all_hi = (smoke_h.size() == P);
      rain_all_hi  = (rain_h.size() == P);
      rain_all_lo  = (rain_h.size() == P);
      foreach (smoke_h[i]) if (smoke_h[i] < SMOKE_ON) smoke_all_hi = 0;
      foreach (rain_h[i]) begin
         if (rain_h[i] < RAIN_ON) rain_all_hi = 0;
         if (rain_h[i] >= RAIN_OFF) rain_all_lo = 0;
      end
      if (smoke_all_hi) m_fire = 1;
      else if (fire_ack && smoke_level < SMOKE_OFF) m_fire = 0;
      if (!m_rain && rain_all_hi) m_rain = 1;
      else if (m_rain && rain_all_lo) m_rain = 0;

      if (m_mode == M_DIS) begin
         if (arm && !disarm) m_mode = M_ARMED;
      end else if (disarm) begin
         m_mode = M_DIS;
      end else if (m_mode == M_ARMED) begin
         if (motion) m_mode = M_ALARM;
         else if (door_open) begin
            m_mode = M_ENTRY;
            entry_edge = edge_cnt;
         end
      end else if (m_mode == M_ENTRY) begin
         if (edge_cnt - entry_edge == ENTRY_DELAY) m_mode = M_ALARM;
      end

      exp_state   = {m_rain, (m_mode == M_ALARM), m_fire};
      exp_changed = (exp_state != prev_state);
      prev_state  = exp_state;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         #1;
         check_eq("state", {5'd0, state}, {5'd0, exp_state});
         check_eq("armed", {7'd0, armed}, {7'd0, (m_mode != M_DIS)});
         check_eq("entry_pending", {7'd0, entry_pending}, {7'd0, (m_mode == M_ENTRY)});
         check_eq("changed", {7'd0, changed}, {7'd0, exp_changed});
      end
   endtask

   // Reset is asserted away from any clock edge so the checks see the asynchronous clear.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("rst_state", {5'd0, state}, 8'd0);
      check_eq("rst_armed", {7'd0, armed}, 8'd0);
      check_eq("rst_entry", {7'd0, entry_pending}, 8'd0);
      check_eq("rst_changed", {7'd0, changed}, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic idle_inputs();
      smoke_level = 8'd0; rain_level = 8'd0;
      door_open = 0; motion = 0; arm = 0; disarm = 0; fire_ack = 0;
   endtask

   function automatic logic [7:0] pick_level(input logic [7:0] cur);
      logic [7:0] table_v[14] = '{8'd0, 8'd30, 8'd39, 8'd40, 8'd41, 8'd79, 8'd80,
                                  8'd99, 8'd100, 8'd120, 8'd149, 8'd150, 8'd200, 8'd255};
      int r = $urandom_range(0, 7);
      if (r < 5) return cur;
      if (r < 7) return table_v[$urandom_range(0, 13)];
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      edge_cnt = 0; entry_edge = 0;
      idle_inputs();
      #2;
      do_reset();

      // Fire: three qualifying samples are not enough, four are.
      smoke_level = 8'd200; tick(3);
      smoke_level = 8'd120; tick(1);
      check_eq("fire_short_run", {5'd0, state}, 8'h00);
      smoke_level = 8'd200; tick(4);
      check_eq("fire_set", {5'd0, state}, 8'h01);
      check_eq("fire_set_changed", {7'd0, changed}, 8'd1);
      smoke_level = 8'd120; fire_ack = 1; tick(2);
      check_eq("fire_ack_ignored", {5'd0, state}, 8'h01);
      check_eq("changed_one_cycle", {7'd0, changed}, 8'd0);
      smoke_level = 8'd90; tick(1);
      check_eq("fire_ack_clear", {5'd0, state}, 8'h00);
      check_eq("fire_clear_changed", {7'd0, changed}, 8'd1);
      fire_ack = 0;

      // Rain hysteresis.
      rain_level = 8'd90; tick(4);
      check_eq("rain_set", {5'd0, state}, 8'h04);
      rain_level = 8'd60; tick(10);
      check_eq("rain_band_hold", {5'd0, state}, 8'h04);
      rain_level = 8'd30; tick(4);
      check_eq("rain_clear", {5'd0, state}, 8'h00);

      // Entry delay expires.
      arm = 1; tick(1); arm = 0;
      check_eq("armed", {7'd0, armed}, 8'd1);
      door_open = 1; tick(1); door_open = 0;
      check_eq("entry_pending", {7'd0, entry_pending}, 8'd1);
      tick(ENTRY_DELAY - 1);
      check_eq("entry_not_yet", {5'd0, state}, 8'h00);
      tick(1);
      check_eq("entry_alarm", {5'd0, state}, 8'h02);
      disarm = 1; tick(1); disarm = 0;
      check_eq("disarm_alarm", {5'd0, state}, 8'h00);

      // Disarm at cycle 10 of the entry delay.
      arm = 1; door_open = 1; tick(1); arm = 0;
      check_eq("arm_door_open_armed_first", {7'd0, entry_pending}, 8'd0);
      tick(1); door_open = 0;
      check_eq("arm_door_open_entry_next", {7'd0, entry_pending}, 8'd1);
      tick(9);
      disarm = 1; tick(1); disarm = 0;
      tick(10);
      check_eq("entry_disarmed_state", {5'd0, state}, 8'h00);
      check_eq("entry_disarmed_armed", {7'd0, armed}, 8'd0);

      // Arm+disarm together, motion, all alarms at once.
      arm = 1; disarm = 1; tick(2); disarm = 0;
      check_eq("arm_disarm_both", {7'd0, armed}, 8'd0);
      tick(1); arm = 0;
      motion = 1; tick(1); motion = 0;
      check_eq("motion_alarm", {5'd0, state}, 8'h02);
      smoke_level = 8'd200; rain_level = 8'd90; tick(4);
      check_eq("all_alarms", {5'd0, state}, 8'h07);
      disarm = 1; smoke_level = 8'd0; rain_level = 8'd0; fire_ack = 1; tick(P);
      disarm = 0; fire_ack = 0;

      // Async reset in the middle of ENTRY with fire latched.
      smoke_level = 8'd200; tick(4); smoke_level = 8'd0;
      arm = 1; tick(1); arm = 0;
      door_open = 1; tick(1); door_open = 0;
      tick(5);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         smoke_level = pick_level(smoke_level);
         rain_level  = pick_level(rain_level);
         door_open   = ($urandom_range(0, 9) == 0);
         motion      = ($urandom_range(0, 29) == 0);
         arm         = ($urandom_range(0, 19) == 0);
         disarm      = ($urandom_range(0, 59) == 0);
         fire_ack    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_sensor_frontend.md
# alarm_sensor_frontend

Sensor-conditioning stage that sits directly upstream of the alarms block in the smart-home controller. Samples raw smoke and rain levels plus door/motion contacts, applies threshold hysteresis, persistence filtering and an arm/entry-delay state machine, and produces the registered 3-bit alarm state vector that the alarms block consumes. Also provides a one-cycle change strobe for the controller.

## Interface
Parameters:
- SMOKE_ON, 8'd150: smoke level at or above which the fire condition is counted
- SMOKE_OFF, 8'd100: smoke level below which fire_ack is honoured
- RAIN_ON, 8'd80: rain level at or above which the rain condition is counted
- RAIN_OFF, 8'd40: rain level below which the rain-clear condition is counted
- PERSIST, 4: consecutive samples required to assert/deassert (1..15)
- ENTRY_DELAY, 16: entry-delay length in cycles (1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- smoke_level  input  8  unsigned smoke sensor reading
- rain_level  input  8  unsigned rain sensor reading
- door_open  input  1  door contact, 1 = open
- motion  input  1  motion detector, 1 = motion
- arm  input  1  level, request arming
- disarm  input  1  level, request disarming
- fire_ack  input  1  operator acknowledge of fire alarm
- state  output  3  alarm vector: bit0 fire, bit1 burglar, bit2 rain
- armed  output  1  1 in ARMED, ENTRY or ALARM
- entry_pending  output  1  1 in ENTRY
- changed  output  1  one-cycle pulse when state differs from its previous value

## Operation
- All inputs sampled on rising clk; all outputs are registers.
- Fire (state[0]): 4-bit counter increments (saturating at PERSIST) while smoke_level >= SMOKE_ON, clears to 0 on any sample below. state[0] sets when counter would reach PERSIST. Latched: clears only on fire_ack sampled high while smoke_level < SMOKE_OFF; fire_ack otherwise ignored. Set condition wins over ack in the same cycle.
- Rain (state[2]): when clear, on-counter counts consecutive samples >= RAIN_ON; sets on PERSIST-th. When set, off-counter counts consecutive samples < RAIN_OFF; clears on PERSIST-th. Sample in the band breaks the run (counter to 0), output holds.
- Burglar FSM, 4 states:
  - DISARMED: arm & !disarm -> ARMED.
  - ARMED: disarm -> DISARMED; else motion -> ALARM; else door_open -> ENTRY, load delay counter with ENTRY_DELAY-1.
  - ENTRY: disarm -> DISARMED; else counter==0 -> ALARM; else decrement. motion during ENTRY does not shorten the delay.
  - ALARM: state[1]=1; disarm -> DISARMED only.
- disarm has priority over arm and over every trigger.
- Arming with door already open: ARMED on that edge, ENTRY on the next.
- changed = 1 for exactly the cycle after the edge on which state took a new value; 0 otherwise.

## Timing
- Reset (reset=0, async): state=3'b000, armed=0, entry_pending=0, changed=0, FSM DISARMED, all counters 0. Release is synchronous to next edge; mid-operation reset drops all alarms, including latched fire, immediately.
- Fire/rain assert latency: PERSIST rising edges after the first qualifying sample (default 4 cycles).
- Rain clear latency: PERSIST edges after first sample < RAIN_OFF.
- Entry: state[1] rises ENTRY_DELAY edges after the edge that entered ENTRY (default 16).
- Motion while ARMED: state[1] rises one edge after motion sampled.
- Disarm: state[1], armed, entry_pending fall one edge after disarm sampled.
- changed coincides with the first cycle the new state is visible.

## Test plan
- Reset then smoke_level=200 for 4 cycles -> state=3'b001 after 4th edge, changed pulses 1 cycle; smoke 200 for only 3 cycles then 120 -> state stays 000.
- Fire latched: smoke drops to 120, fire_ack=1 -> state[0] stays 1; smoke 90, fire_ack=1 -> state[0]=0 next edge, changed pulses.
- Rain hysteresis: rain_level=90 x4 -> state=3'b100; rain 60 x10 -> stays 100; rain 30 x4 -> state=000.
- Arm, door_open=1 -> entry_pending=1; no disarm -> state=3'b010 exactly 16 cycles later; repeat with disarm at cycle 10 -> state stays 000, armed=0.
- Arm and disarm both high -> stays DISARMED; armed, motion=1 -> state=010 after one edge; smoke+rain+burglar together -> state=3'b111.
- Reset asserted mid-ENTRY with fire latched -> all outputs 0 immediately, without waiting for clk.
